// File: rtl/matrix_loader.sv
// Purpose : assembles a byte stream into a packed NxN (N=2..5) signed-int8 matrix bus.
// Latency : start -> in_ready 1 cycle; last accepted byte -> out_valid 1 cycle (min A+1 from start).
// Backpr. : in_ready only in LOAD; the matrix is held frozen in DONE until out_ready.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start, matrix_size  load request; the size code is latched when start is taken in IDLE
//   in_data/in_valid/in_ready          row-major element stream
//   matrix_A/matrix_size_out/out_valid/out_ready  completed matrix toward the operation stage
//   busy                high in LOAD or DONE
//   error               one-cycle abort pulse on idle timeout
//
// Optional build macro MATRIX_LOADER_TIMEOUT_EN enables the idle timeout (TIMEOUT_CYCLES).
// Without it LOAD waits indefinitely and error is tied 0.
module matrix_loader #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   matrix_size,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [199:0] matrix_A,
    output logic [1:0]   matrix_size_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] count;
    logic [4:0] active;
    logic       accept;
    logic       last_beat;
    logic       timeout_hit;

    always_comb begin
        active = 5'd4;
        case (matrix_size_out)
            2'b00:   active = 5'd4;
            2'b01:   active = 5'd9;
            2'b10:   active = 5'd16;
            default: active = 5'd25;
        endcase
    end

    assign accept    = (state == S_LOAD) && in_valid;
    assign last_beat = accept && (count == active - 5'd1);

`ifdef MATRIX_LOADER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] idle_cnt;
    logic        error_q;

    // Abort on the edge where the idle count would reach the limit, so the
    // error pulse appears exactly TIMEOUT_CYCLES cycles after the last byte.
    assign timeout_hit = (state == S_LOAD) && !accept &&
                         ((idle_cnt + 16'd1) == TIMEOUT_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= 16'd0;
            error_q  <= 1'b0;
        end else begin
            error_q <= timeout_hit;
            if (state != S_LOAD || accept) begin
                idle_cnt <= 16'd0;
            end else begin
                idle_cnt <= idle_cnt + 16'd1;
            end
        end
    end

    assign error = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^(32'(TIMEOUT_CYCLES));
    assign timeout_hit    = 1'b0;
    assign error          = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end else if (last_beat) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Clearing the whole bus at start is what keeps inactive elements zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            matrix_A        <= '0;
            matrix_size_out <= 2'b00;
            count           <= 5'd0;
        end else if (state == S_IDLE && start) begin
            matrix_A        <= '0;
            matrix_size_out <= matrix_size;
            count           <= 5'd0;
        end else if (timeout_hit) begin
            matrix_A <= '0;
            count    <= 5'd0;
        end else if (accept) begin
            matrix_A[{count, 3'b000} +: 8] <= in_data;
            count                          <= count + 5'd1;
        end
    end

    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_LOAD) || (state == S_DONE);

endmodule

// File: tb/tb_matrix_loader.sv
// Purpose : self-checking bench for matrix_loader against a packing model of the byte stream.
// Latency : n/a (bench).
// Backpr. : drives out_ready low/high to exercise the DONE hold.
module tb_matrix_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   matrix_size;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [199:0] matrix_A;
    logic [1:0]   matrix_size_out;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] bytes [25];

    always #5 clk = ~clk;

    matrix_loader dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .matrix_size     (matrix_size),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .matrix_A        (matrix_A),
        .matrix_size_out (matrix_size_out),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .busy            (busy),
        .error           (error)
    );

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected bus: the first A streamed bytes in element order, everything else zero.
    function automatic logic [199:0] model(input int a);
        logic [199:0] m;
        m = '0;
        for (int i = 0; i < a; i++) m[i*8 +: 8] = bytes[i];
        return m;
    endfunction

    function automatic int elems(input logic [1:0] sz);
        return (int'(sz) + 2) * (int'(sz) + 2);
    endfunction

    // mode 0: back-to-back, 1: in_valid every other cycle, 2: random in_valid
    task automatic load(input logic [1:0] sz, input int mode, input string tag);
        int a;
        int acc;
        int cyc;
        a   = elems(sz);
        acc = 0;
        in_valid    = 1'b0;
        start       = 1'b1;
        matrix_size = sz;
        tick();
        start = 1'b0;
        cyc   = 1;
        check({tag, " ready_after_start"}, 200'(in_ready), 200'(1));
        while (acc < a && cyc < 400) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2) == 1;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? bytes[acc] : 8'($urandom);
            if (in_valid && in_ready) acc++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, " handshakes"}, 200'(acc), 200'(a));
        if (mode == 0) check({tag, " start_to_valid_cycles"}, 200'(cyc), 200'(a + 1));
        check({tag, " out_valid"}, 200'(out_valid), 200'(1));
        check({tag, " ready_dropped"}, 200'(in_ready), 200'(0));
        check({tag, " matrix"}, matrix_A, model(a));
        check({tag, " size_out"}, 200'(matrix_size_out), 200'(sz));
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " drain_out_valid"}, 200'(out_valid), 200'(0));
        check({tag, " drain_busy"}, 200'(busy), 200'(0));
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        matrix_size = 2'b00;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        tick();
        tick();
        check("reset matrix_A", matrix_A, '0);
        check("reset ctrl", 200'({in_ready, out_valid, busy, error, matrix_size_out}), 200'(0));
        rst = 1'b0;
        tick();

        // Asynchronous reset in the middle of a 3x3 load.
        for (int i = 0; i < 25; i++) bytes[i] = 8'($urandom_range(1, 255));
        start       = 1'b1;
        matrix_size = 2'b01;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = bytes[i];
            tick();
        end
        in_valid = 1'b0;
        check("midload busy", 200'(busy), 200'(1));
        #1 rst = 1'b1;
        #1;
        check("async reset matrix_A", matrix_A, '0);
        check("async reset ctrl", 200'({in_ready, out_valid, busy, matrix_size_out}), 200'(0));
        tick();
        rst = 1'b0;
        tick();
        load(2'b01, 0, "post_reset 3x3");
        drain("post_reset 3x3");

        // 2x2 with boundary byte values.
        bytes[0] = 8'h01; bytes[1] = 8'hFF; bytes[2] = 8'h80; bytes[3] = 8'h7F;
        load(2'b00, 0, "2x2");
        check("2x2 low word", 200'(matrix_A[31:0]), 200'(32'h7F80FF01));
        check("2x2 upper zero", 200'(matrix_A[199:32]), 200'(0));
        drain("2x2");

        // 5x5 with in_valid toggling, then a DONE hold with distractions.
        for (int i = 0; i < 25; i++) bytes[i] = 8'(i + 1);
        load(2'b11, 1, "5x5");
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick();
        check("5x5 no extra byte", matrix_A, model(25));
        for (int c = 0; c < 10; c++) begin
            start    = (c % 2) == 0;
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick();
            check("hold out_valid", 200'(out_valid), 200'(1));
            check("hold matrix", matrix_A, model(25));
            check("hold size", 200'(matrix_size_out), 200'(2'b11));
        end
        start    = 1'b0;
        in_valid = 1'b0;
        drain("5x5");

        // Back-to-back 4x4 then 2x2: no residue from the larger matrix.
        for (int i = 0; i < 25; i++) bytes[i] = 8'($urandom_range(1, 255));
        load(2'b10, 0, "b2b 4x4");
        drain("b2b 4x4");
        for (int i = 0; i < 25; i++) bytes[i] = 8'($urandom_range(1, 255));
        load(2'b00, 0, "b2b 2x2");
        check("b2b residue", 200'(matrix_A[199:32]), 200'(0));
        // start coinciding with out_ready in DONE must be ignored.
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        check("start_in_done busy", 200'(busy), 200'(0));
        tick();
        check("start_in_done stays idle", 200'({busy, in_ready}), 200'(0));

        // Randomised sizes and input gaps.
        for (int t = 0; t < 8; t++) begin
            logic [1:0] sz;
            sz = 2'($urandom_range(0, 3));
            for (int i = 0; i < 25; i++) bytes[i] = 8'($urandom);
            load(sz, 2, "random");
            drain("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

endmodule
